// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receiver and transmitter
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLOCKS_PER_BIT_DEFAULT = 80000;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready channel with error pulses
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport master (output o_data, output o_valid, output o_frame_err, output o_overrun,
                  input i_ready);
  modport slave  (input o_data, input o_valid, input o_frame_err, input o_overrun,
                  output i_ready);
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for asynchronous serial control lines
module uart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-byte holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = CLOCKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  output logic        o_busy,
  uart_rx_if.master   rx
);
  localparam int CW = $clog2(clocks_per_bit);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(clocks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(clocks_per_bit - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;

  uart_sync #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RX_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      rx.o_data      <= '0;
      rx.o_valid     <= 1'b0;
      rx.o_frame_err <= 1'b0;
      rx.o_overrun   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      rx.o_frame_err <= 1'b0;
      rx.o_overrun   <= 1'b0;
      // A delivery later in this block overrides the clear when both happen together.
      if (rx.o_valid && rx.i_ready) begin
        rx.o_valid <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt    <= HALF_LOAD;
            state  <= RX_START;
            o_busy <= 1'b1;
          end
        end

        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state  <= RX_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= RX_DATA;
          end
        end

        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + IW'(1);
            if (bit_idx == LAST_BIT) begin
              state <= RX_STOP;
            end
          end
        end

        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            if (!rx.o_valid || rx.i_ready) begin
              rx.o_data  <= shift;
              rx.o_valid <= 1'b1;
            end else begin
              rx.o_overrun <= 1'b1;
            end
            state  <= RX_IDLE;
            o_busy <= 1'b0;
          end else begin
            rx.o_frame_err <= 1'b1;
            state          <= RX_WAIT_IDLE;
          end
        end

        RX_WAIT_IDLE: begin
          if (rx_s) begin
            state  <= RX_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= RX_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
